// File: rtl/iob_mtimer_resp.sv
`timescale 1ns/1ps
// Native-bus machine timer (msip, mtimecmp, mtime) with a prescaled mtime tick.
// Latency: response one cycle after the request is sampled; mtip lags register state by one cycle.
// Backpressure: none, so a request is accepted every cycle valid is high. Optional MTIME_LATCH_EN adds a tear-free mtime hi shadow.
module iob_mtimer_resp #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int PRESCALE = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                mtip,
  output logic                msip
);

  // Word-address decode constants (byte offsets shifted down by 2).
  localparam int WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] WA_MSIP    = WA_W'(16'h0000 >> 2);
  localparam logic [WA_W-1:0] WA_CMP_LO  = WA_W'(16'h4000 >> 2);
  localparam logic [WA_W-1:0] WA_CMP_HI  = WA_W'(16'h4004 >> 2);
  localparam logic [WA_W-1:0] WA_TIME_LO = WA_W'(16'hBFF8 >> 2);
  localparam logic [WA_W-1:0] WA_TIME_HI = WA_W'(16'hBFFC >> 2);

  // Prescaler counter sizing; a PRESCALE of 1 still needs a 1-bit counter.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [WA_W-1:0]   word_addr;
  logic              req_wr;
  logic              req_rd;
  logic              sel_msip;
  logic              sel_cmp_lo;
  logic              sel_cmp_hi;
  logic              sel_time_lo;
  logic              sel_time_hi;
  logic              wr_msip;
  logic              wr_cmp_lo;
  logic              wr_cmp_hi;
  logic              wr_time_lo;
  logic              wr_time_hi;
  logic [PW-1:0]     presc_cnt;
  logic              tick;
  logic [63:0]       mtime;
  logic [63:0]       mtimecmp;
  logic              msip_q;
  logic [DATA_W-1:0] time_hi_rd;
  logic [DATA_W-1:0] rd_val;
  logic              unused_addr_lsb;

  // Byte lanes below word granularity carry no meaning for this map.
  assign unused_addr_lsb = ^address[1:0];

  // Merge write data into an existing word under the byte enables.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]   old_v,
    input logic [DATA_W-1:0]   new_v,
    input logic [DATA_W/8-1:0] be
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign word_addr = address[ADDR_W-1:2];
  assign req_wr    = valid && (wstrb != '0);
  assign req_rd    = valid && (wstrb == '0);

  assign sel_msip    = (word_addr == WA_MSIP);
  assign sel_cmp_lo  = (word_addr == WA_CMP_LO);
  assign sel_cmp_hi  = (word_addr == WA_CMP_HI);
  assign sel_time_lo = (word_addr == WA_TIME_LO);
  assign sel_time_hi = (word_addr == WA_TIME_HI);

  assign wr_msip    = req_wr && sel_msip && wstrb[0];
  assign wr_cmp_lo  = req_wr && sel_cmp_lo;
  assign wr_cmp_hi  = req_wr && sel_cmp_hi;
  assign wr_time_lo = req_wr && sel_time_lo;
  assign wr_time_hi = req_wr && sel_time_hi;

  assign tick = (presc_cnt == PMAX);

  // Prescaler free-runs 0..PRESCALE-1; bus writes never disturb its phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

  // mtime: a bus write to either half takes priority and suppresses that cycle's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime <= '0;
    end else if (wr_time_lo || wr_time_hi) begin
      if (wr_time_lo) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], wdata, wstrb);
      end
      if (wr_time_hi) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrb);
      end
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp halves, byte-granular writes; resets to all ones so mtip starts low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtimecmp <= '1;
    end else begin
      if (wr_cmp_lo) begin
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wdata, wstrb);
      end
      if (wr_cmp_hi) begin
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, wstrb);
      end
    end
  end

  // Software interrupt bit, only the lowest byte lane reaches it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msip_q <= 1'b0;
    end else if (wr_msip) begin
      msip_q <= wdata[0];
    end
  end

  assign msip = msip_q;

  // Registered level compare; follows register updates one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtip <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp);
    end
  end

`ifdef MTIME_LATCH_EN
  logic [31:0] time_hi_shadow;

  // A lo read snapshots the live upper half so the following hi read cannot tear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_hi_shadow <= '0;
    end else if (req_rd && sel_time_lo) begin
      time_hi_shadow <= mtime[63:32];
    end
  end

  assign time_hi_rd = time_hi_shadow;
`else
  assign time_hi_rd = mtime[63:32];
`endif

  // Read mux over pre-edge register state; unmapped words read zero.
  always_comb begin
    rd_val = '0;
    if (sel_msip) begin
      rd_val = {{(DATA_W-1){1'b0}}, msip_q};
    end else if (sel_cmp_lo) begin
      rd_val = mtimecmp[31:0];
    end else if (sel_cmp_hi) begin
      rd_val = mtimecmp[63:32];
    end else if (sel_time_lo) begin
      rd_val = mtime[31:0];
    end else if (sel_time_hi) begin
      rd_val = time_hi_rd;
    end
  end

  // One-cycle response strobe per request; rdata only moves on reads and holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      if (req_rd) begin
        rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_iob_mtimer_resp.sv
`timescale 1ns/1ps
module tb_iob_mtimer_resp;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        mtip;
  logic        msip;

  typedef struct {
    logic [31:0] val;
    logic [15:0] addr;
    bit          chk;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned edges;
  int unsigned base;

`ifdef MTIME_LATCH_EN
  localparam logic [31:0] LATCH_HI_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] LATCH_HI_EXP = 32'h0000_0001;
`endif

  iob_mtimer_resp #(.ADDR_W(16), .DATA_W(32), .PRESCALE(100)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .ready   (ready),
    .mtip    (mtip),
    .msip    (msip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the prescaler ticks on every edge that is a multiple of 100.
  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; leaves the request on the bus and returns at the next negedge.
  task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit chk, input logic [31:0] exp);
    exp_t e;
    valid   = 1'b1;
    address = a;
    wdata   = d;
    wstrb   = s;
    e.val   = exp;
    e.addr  = a;
    e.chk   = chk;
    e.due   = edges + 1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(a, d, s, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    bus(a, 32'h0, 4'h0, 1'b1, exp);
  endtask

  task automatic idle();
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic align(input int unsigned p);
    idle();
    while ((edges % 100) != p) @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned t);
    idle();
    while (edges < t) @(negedge clk);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 64'(ready), 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_latency", 64'(edges), 64'(e.due));
          if (e.chk) check($sformatf("rdata@%h", e.addr), 64'(rdata), 64'(e.val));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    valid    = 1'b0;
    address  = 16'h0;
    wdata    = 32'h0;
    wstrb    = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset
    repeat (10) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_mtip",  64'(mtip),  64'd0);
    check("reset_msip",  64'(msip),  64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);

    // Reset values over the bus, including an unmapped word
    rd(16'h4004, 32'hFFFF_FFFF);
    rd(16'h4000, 32'hFFFF_FFFF);
    rd(16'h0000, 32'h0);
    rd(16'hBFFC, 32'h0);
    rd(16'h1234, 32'h0);
    idle();
    @(negedge clk);

    // msip set / clear / wrong byte lane / only bit0 reads back
    wr(16'h0000, 32'h1, 4'hF); idle();
    check("msip_set", 64'(msip), 64'd1);
    wr(16'h0000, 32'h0, 4'hF); idle();
    check("msip_clr", 64'(msip), 64'd0);
    wr(16'h0000, 32'h1, 4'h2); idle();
    check("msip_lane", 64'(msip), 64'd0);
    wr(16'h0000, 32'hFFFF_FFFF, 4'hF);
    rd(16'h0000, 32'h1);
    wr(16'h0000, 32'h0, 4'hF);
    idle();

    // Unmapped write ignored
    wr(16'h2000, 32'hDEAD_BEEF, 4'hF);
    rd(16'h2000, 32'h0);

    // Back-to-back alternating write/read of mtime lo, away from any tick
    align(10);
    wr(16'hBFF8, 32'h1111_1111, 4'hF);
    rd(16'hBFF8, 32'h1111_1111);
    wr(16'hBFF8, 32'hAABB_CCDD, 4'h3);
    rd(16'hBFF8, 32'h1111_CCDD);
    idle();
    repeat (2) @(negedge clk);
    check("b2b_drained", 64'(sb.size()), 64'd0);

    // Write on the tick edge wins: edge 99 hi=0, edge 100 (tick) lo=5, read sees 5
    align(98);
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'h5, 4'hF);
    rd(16'hBFF8, 32'h5);
    idle();

    // mtip rise: mtime=0, mtimecmp=10, ten ticks later mtip goes high one cycle after
    align(10);
    base = edges;
    wr(16'hBFF8, 32'h0, 4'hF);
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'h4000, 32'd10, 4'hF);
    wr(16'h4004, 32'h0, 4'hF);
    idle();
    @(negedge clk);
    check("mtip_low_early", 64'(mtip), 64'd0);
    wait_until(base + 990);
    check("mtip_low_at_10", 64'(mtip), 64'd0);
    rd(16'hBFF8, 32'd10);
    idle();
    check("mtip_rise", 64'(mtip), 64'd1);
    wait_until(base + 995);
    wr(16'h4004, 32'h1, 4'hF);
    idle();
    check("mtip_hold", 64'(mtip), 64'd1);
    @(negedge clk);
    check("mtip_fall", 64'(mtip), 64'd0);

    // Wrap: mtimecmp=1, mtime=all ones, next tick wraps to 0 and mtip drops
    align(10);
    base = edges;
    wr(16'h4000, 32'h1, 4'hF);
    wr(16'h4004, 32'h0, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wait_until(base + 89);
    check("wrap_mtip_pre", 64'(mtip), 64'd1);
    wait_until(base + 91);
    check("wrap_mtip_post", 64'(mtip), 64'd0);
    rd(16'hBFF8, 32'h0);
    rd(16'hBFFC, 32'h0);
    idle();

    // Lo-then-hi read across a tick that carries into the upper half
    align(10);
    base = edges;
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFFC, 32'h0, 4'hF);
    rd(16'hBFF8, 32'hFFFF_FFFF);
    wait_until(base + 94);
    rd(16'hBFFC, LATCH_HI_EXP);
    rd(16'hBFF8, 32'h0);
    rd(16'hBFFC, 32'h1);
    idle();
    repeat (2) @(negedge clk);

    // Reset in the middle of a transaction drops the response
    wr(16'h0000, 32'h1, 4'hF);
    idle();
    check("pre_rst_msip", 64'(msip), 64'd1);
    valid   = 1'b1;
    address = 16'h4004;
    wstrb   = 4'h0;
    @(posedge clk);
    #0.5;
    reset = 1'b0;
    valid = 1'b0;
    #1;
    check("rst_ready_drop", 64'(ready), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_ready", 64'(ready), 64'd0);
    check("post_rst_msip",  64'(msip),  64'd0);
    check("post_rst_mtip",  64'(mtip),  64'd0);
    rd(16'h4004, 32'hFFFF_FFFF);
    rd(16'hBFF8, 32'h0);
    idle();

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
